// File: rtl/wr_stream_packer_if.sv
// Byte-stream input and FIFO write-port bundle for wr_stream_packer.
// slave = packer side, master = the stream source / FIFO side.
interface wr_stream_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_last;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_full;
  logic                  pkt_done;
  logic [CNT_WIDTH-1:0]  pkt_words;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, in_last, fifo_full,
    input  in_ready, fifo_wr_en, fifo_wr_data, pkt_done, pkt_words, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, fifo_full,
    output in_ready, fifo_wr_en, fifo_wr_data, pkt_done, pkt_words, stall_cnt
  );
endinterface

// File: rtl/wr_stream_packer.sv
// Write-side feeder for the async FIFO: packs a narrow byte stream little-endian
// into FIFO words, pads the tail of each packet, and reports packet/stall stats.
module wr_stream_packer #(
  parameter int                 DATA_WIDTH = 32,
  parameter int                 IN_WIDTH   = 8,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0,
  parameter int                 CNT_WIDTH  = 16
) (
  input  logic                 wr_clk,
  input  logic                 wreset_n,
  wr_stream_packer_if.slave    pk_if
);

  localparam int RATIO  = DATA_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(RATIO);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  run_q;
  logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]  pkt_words_q, pkt_words_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic                  pkt_done_q, pkt_done_d;

  logic rdy, accept, fire, complete;

  // Insert a beat at its lane; every lane above it takes the pad value so a
  // final partial word is already padded when it leaves the accumulator.
  function automatic logic [DATA_WIDTH-1:0] pack_word(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [LANE_W-1:0]     lane,
    input logic [IN_WIDTH-1:0]   beat
  );
    logic [DATA_WIDTH-1:0] w;
    w = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (i == int'(lane))     w[i*IN_WIDTH +: IN_WIDTH] = beat;
      else if (i > int'(lane)) w[i*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
    end
    return w;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    wcnt_d      = wcnt_q;
    pkt_words_d = pkt_words_q;
    pkt_done_d  = 1'b0;
    stall_d     = stall_q;

    fire     = hold_vld_q && !pk_if.fifo_full;
    rdy      = run_q && (state_q != DRAIN) && (!hold_vld_q || !pk_if.fifo_full);
    accept   = pk_if.in_valid && rdy;
    complete = accept && (pk_if.in_last || (lane_q == LANE_W'(RATIO-1)));

    if (hold_vld_q && pk_if.fifo_full) stall_d = sat_inc(stall_q);

    // In DRAIN the hold register can only contain the packet's final word.
    if (fire) begin
      hold_vld_d = 1'b0;
      if (state_q == DRAIN) begin
        pkt_done_d  = 1'b1;
        pkt_words_d = wcnt_q + CNT_WIDTH'(1);
        wcnt_d      = '0;
        state_d     = IDLE;
      end else begin
        wcnt_d = wcnt_q + CNT_WIDTH'(1);
      end
    end

    if (accept) begin
      if (complete) begin
        hold_d     = pack_word(acc_q, lane_q, pk_if.in_data);
        hold_vld_d = 1'b1;
        acc_d      = '0;
        lane_d     = '0;
      end else begin
        acc_d  = pack_word(acc_q, lane_q, pk_if.in_data);
        lane_d = lane_q + LANE_W'(1);
      end
      state_d = pk_if.in_last ? DRAIN : ACCUM;
    end
  end

  always_ff @(posedge wr_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      acc_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      run_q       <= 1'b0;
      wcnt_q      <= '0;
      pkt_words_q <= '0;
      pkt_done_q  <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      run_q       <= 1'b1;
      wcnt_q      <= wcnt_d;
      pkt_words_q <= pkt_words_d;
      pkt_done_q  <= pkt_done_d;
      stall_q     <= stall_d;
    end
  end

  assign pk_if.in_ready     = rdy;
  assign pk_if.fifo_wr_en   = fire;
  assign pk_if.fifo_wr_data = hold_q;
  assign pk_if.pkt_done     = pkt_done_q;
  assign pk_if.pkt_words    = pkt_words_q;
  assign pk_if.stall_cnt    = stall_q;

endmodule

// File: tb/tb_wr_stream_packer.sv
// Scoreboard bench for wr_stream_packer: directed packets plus randomized
// packets under random FIFO back-pressure, checked against a packet-level model.
module tb_wr_stream_packer;
  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int CW    = 16;
  localparam int RATIO = DW / IW;
  localparam logic [IW-1:0] PAD = 8'h00;

  logic wr_clk   = 1'b0;
  logic wreset_n = 1'b0;

  wr_stream_packer_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  wr_stream_packer #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .PAD_VALUE(PAD), .CNT_WIDTH(CW)) dut (
    .wr_clk  (wr_clk),
    .wreset_n(wreset_n),
    .pk_if   (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats_acc = 0;
  bit rand_on = 0;

  logic [DW-1:0] wq[$];
  int            pq[$];
  logic [IW-1:0] pb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: words pending toward the FIFO, whether the packet's
  // last beat has been taken, beats within the current word, and stall cycles.
  int m_pend  = 0;
  int m_lane  = 0;
  int m_stall = 0;
  bit m_drain = 0;
  bit m_run   = 0;
  bit m_done  = 0;

  always @(negedge wr_clk) begin
    bit ewr, erdy, acc, comp;
    cyc++;
    if (!wreset_n) begin
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_wr_en", bus.fifo_wr_en, 0);
      check("rst_wr_data", bus.fifo_wr_data, 0);
      check("rst_pkt_done", bus.pkt_done, 0);
      check("rst_pkt_words", bus.pkt_words, 0);
      check("rst_stall_cnt", bus.stall_cnt, 0);
      m_pend = 0; m_lane = 0; m_stall = 0; m_drain = 0; m_run = 0; m_done = 0;
    end else begin
      ewr  = (m_pend > 0) && !bus.fifo_full;
      erdy = m_run && !m_drain && ((m_pend == 0) || !bus.fifo_full);
      check("wr_en", bus.fifo_wr_en, ewr);
      check("in_ready", bus.in_ready, erdy);
      check("pkt_done", bus.pkt_done, m_done);
      if (bus.fifo_wr_en) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_data: got unexpected write %0h want no write", bus.fifo_wr_data);
        end else check("wr_data", bus.fifo_wr_data, wq.pop_front());
      end
      if (bus.pkt_done) begin
        if (pq.size() == 0) begin
          total++; bad++;
          $display("FAIL pkt_words: got unexpected pkt_done (%0d) want none", bus.pkt_words);
        end else check("pkt_words", bus.pkt_words, pq.pop_front());
      end
      acc  = bus.in_valid && bus.in_ready;
      comp = acc && (bus.in_last || (m_lane == RATIO - 1));
      if ((m_pend > 0) && bus.fifo_full) m_stall++;
      m_done = m_drain && ewr;
      if (m_drain && ewr) m_drain = 0;
      if (ewr) m_pend--;
      if (comp) m_pend++;
      if (acc) begin
        m_lane = comp ? 0 : m_lane + 1;
        if (bus.in_last) m_drain = 1;
      end
      m_run = 1;
    end
  end

  task automatic send_beat(input logic [IW-1:0] d, input logic last);
    bit ok = 0;
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!ok && waited < 300) begin
      @(negedge wr_clk);
      ok = bus.in_ready;
      @(posedge wr_clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (ok) beats_acc++;
    else begin
      total++; bad++;
      $display("FAIL beat_accept: got no in_ready within %0d cycles want acceptance", waited);
    end
  endtask

  // Expected words are derived straight from the byte list: little-endian lanes,
  // missing tail lanes replaced by the pad value.
  task automatic send_pkt(input int n, input int gap_max);
    int nw;
    logic [DW-1:0] w;
    nw = (n + RATIO - 1) / RATIO;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < RATIO; j++)
        w[j*IW +: IW] = (k*RATIO + j < n) ? pb[k*RATIO + j] : PAD;
      wq.push_back(w);
    end
    pq.push_back(nw);
    for (int b = 0; b < n; b++) begin
      send_beat(pb[b], b == n - 1);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge wr_clk);
        #1;
      end
    end
  endtask

  task automatic fill_rand(input int n);
    pb.delete();
    for (int i = 0; i < n; i++) pb.push_back(IW'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wq.size() != 0 || pq.size() != 0) && n < 500) begin
      @(posedge wr_clk);
      #1;
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL drain: got %0d words %0d pkts outstanding want 0", wq.size(), pq.size());
    end
    repeat (2) @(posedge wr_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by %0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.in_last   = 1'b0;
    bus.fifo_full = 1'b0;
    wreset_n      = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1;
    bus.in_valid = 1'b0;
    wreset_n     = 1'b1;
    @(posedge wr_clk);
    #1;
    check("ready_after_release", bus.in_ready, 1);

    // Full word
    pb = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(4, 0);
    wait_idle();

    // Partial word, then a second packet that must wait for the padded write
    pb = '{8'hAA, 8'hBB};
    send_pkt(2, 0);
    check("blocked_in_drain", bus.in_ready, 0);
    fill_rand(4);
    send_pkt(4, 0);
    wait_idle();

    // Back-pressure: FIFO full for 5 cycles once the first word is held
    check("stall_before_bp", bus.stall_cnt, 0);
    fill_rand(8);
    base = beats_acc;
    fork
      send_pkt(8, 0);
      begin
        wait (beats_acc == base + 4);
        bus.fifo_full = 1'b1;
        repeat (5) @(posedge wr_clk);
        #1;
        bus.fifo_full = 1'b0;
      end
    join
    wait_idle();
    check("bp_stall_cnt", bus.stall_cnt, 5);

    // Streaming 64 beats, one per cycle
    fill_rand(64);
    c0 = cyc;
    send_pkt(64, 0);
    check("stream_cycles", cyc - c0, 64);
    wait_idle();

    // Reset in the middle of a packet discards it
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    wreset_n = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    wreset_n = 1'b1;
    @(posedge wr_clk);
    #1;
    pb = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(4, 0);
    wait_idle();

    // Random packets under random back-pressure
    rand_on = 1;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          fill_rand($urandom_range(1, 13));
          send_pkt(pb.size(), $urandom_range(0, 2));
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge wr_clk);
          #1;
          bus.fifo_full = ($urandom_range(0, 2) == 0);
        end
        bus.fifo_full = 1'b0;
      end
    join
    bus.fifo_full = 1'b0;
    wait_idle();
    check("final_stall_cnt", bus.stall_cnt, m_stall);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
